// File: rtl/serial_tx_pkg.sv
// Shared definitions for the serial link: frame state encoding, line levels,
// and counter sizing used by both ends of the link.
package serial_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } txState_e;

  localparam logic LINE_IDLE   = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

  // A counter for n values needs at least one bit, even when n is 1.
  function automatic int cntWidth(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_tx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and flags the
// terminal count so the transmitter knows when to move to the next bit.
module bit_timer
  import serial_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = cntWidth(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_q <= '0;
    end else if (count_q == LAST) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + CW'(1);
    end
  end

  assign tick = ~clear & (count_q == LAST);

endmodule

// File: rtl/serial_tx.sv
// Serial transmitter: takes a word over valid/ready and sends it as
// start, LSB-first data, optional parity, stop, each held CLKS_PER_BIT clocks.
module serial_tx
  import serial_tx_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tx_valid,
  input  logic [WIDTH-1:0] tx_data,
  output logic             tx_ready,
  output logic             tx_line,
  output logic             busy,
  output logic             done
);

  localparam int BW = cntWidth(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  txState_e         state_q;
  logic [WIDTH-1:0] shiftReg_q;
  logic [WIDTH-1:0] shiftReg_d;
  logic [BW-1:0]    bitCount_q;
  logic             parity_q;
  logic             line_q;
  logic             ready_q;
  logic             done_q;
  logic             accept;
  logic             timerClear;
  logic             tick;

  assign accept     = tx_valid & ready_q;
  assign shiftReg_d = shiftReg_q >> 1;
  assign timerClear = (state_q == ST_IDLE);

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) uTimer (
    .clk  (clk),
    .reset(reset),
    .clear(timerClear),
    .tick (tick)
  );

  // Parity accumulates over the bits as they leave the shift register, seeded
  // with 1 for odd parity so the final value is ~^data rather than ^data.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      line_q     <= LINE_IDLE;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      shiftReg_q <= '0;
      bitCount_q <= '0;
      parity_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q    <= ST_START;
            line_q     <= START_LEVEL;
            ready_q    <= 1'b0;
            shiftReg_q <= tx_data;
            bitCount_q <= '0;
            parity_q   <= (PARITY_ODD != 0);
          end
        end
        ST_START: begin
          if (tick) begin
            state_q <= ST_DATA;
            line_q  <= shiftReg_q[0];
          end
        end
        ST_DATA: begin
          if (tick) begin
            parity_q   <= parity_q ^ shiftReg_q[0];
            shiftReg_q <= shiftReg_d;
            if (bitCount_q == LAST_BIT) begin
              bitCount_q <= '0;
              if (PARITY_EN != 0) begin
                state_q <= ST_PARITY;
                line_q  <= parity_q ^ shiftReg_q[0];
              end else begin
                state_q <= ST_STOP;
                line_q  <= STOP_LEVEL;
              end
            end else begin
              bitCount_q <= bitCount_q + BW'(1);
              line_q     <= shiftReg_d[0];
            end
          end
        end
        ST_PARITY: begin
          if (tick) begin
            state_q <= ST_STOP;
            line_q  <= STOP_LEVEL;
          end
        end
        ST_STOP: begin
          if (tick) begin
            state_q <= ST_IDLE;
            line_q  <= LINE_IDLE;
            ready_q <= 1'b1;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          line_q  <= LINE_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign tx_line  = line_q;
  assign tx_ready = ready_q;
  assign busy     = ~ready_q;
  assign done     = done_q;

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: four configurations (plain, even parity, odd parity,
// one clock per bit) checked cycle by cycle against a frame-bit queue model.
module tb_serial_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       txValid;
  logic [7:0] txData;
  logic [1:0] validSel;
  logic [3:0] validV;
  logic [3:0] lineV, readyV, busyV, doneV;

  int assertCount = 0;
  int failCount   = 0;

  always #5 clk = ~clk;

  always_comb begin
    validV = '0;
    validV[validSel] = txValid;
  end

  serial_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0)) dut0 (
    .clk(clk), .reset(reset), .tx_valid(validV[0]), .tx_data(txData),
    .tx_ready(readyV[0]), .tx_line(lineV[0]), .busy(busyV[0]), .done(doneV[0]));
  serial_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0)) dut1 (
    .clk(clk), .reset(reset), .tx_valid(validV[1]), .tx_data(txData),
    .tx_ready(readyV[1]), .tx_line(lineV[1]), .busy(busyV[1]), .done(doneV[1]));
  serial_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1)) dut2 (
    .clk(clk), .reset(reset), .tx_valid(validV[2]), .tx_data(txData),
    .tx_ready(readyV[2]), .tx_line(lineV[2]), .busy(busyV[2]), .done(doneV[2]));
  serial_tx #(.WIDTH(8), .CLKS_PER_BIT(1), .PARITY_EN(0), .PARITY_ODD(0)) dut3 (
    .clk(clk), .reset(reset), .tx_valid(validV[3]), .tx_data(txData),
    .tx_ready(readyV[3]), .tx_line(lineV[3]), .busy(busyV[3]), .done(doneV[3]));

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void cfg(input int sel, output int cpb, output int pe, output int po);
    cpb = (sel == 3) ? 1 : 4;
    pe  = (sel == 1 || sel == 2) ? 1 : 0;
    po  = (sel == 2) ? 1 : 0;
  endfunction

  // Sends one word to the selected DUT and checks every cycle of the frame
  // against the list of frame bits. With keepValid the request stays high so
  // the caller can chain a second frame straight after done.
  task automatic applyStimulus(input int sel, input logic [7:0] data,
                               input bit keepValid, input bit scramble);
    int cpb, pe, po, frameLen, waitCycles;
    bit bits[$];
    cfg(sel, cpb, pe, po);
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(data[i]);
    if (pe != 0) bits.push_back((po != 0) ? ~^data : ^data);
    bits.push_back(1'b1);
    frameLen = bits.size() * cpb;

    waitCycles = 0;
    while (readyV[sel] !== 1'b1 && waitCycles < 200) begin
      @(negedge clk);
      waitCycles++;
    end
    checkOutput("readyBeforeSend", readyV[sel], 1);

    validSel = 2'(sel);
    txValid  = 1'b1;
    txData   = data;
    @(negedge clk);
    if (!keepValid) txValid = 1'b0;

    for (int k = 0; k < frameLen; k++) begin
      if (scramble) txData = 8'($urandom);
      checkOutput("frameLine", lineV[sel], bits[k / cpb]);
      checkOutput("frameReady", readyV[sel], 0);
      checkOutput("frameBusy", busyV[sel], 1);
      checkOutput("frameDone", doneV[sel], 0);
      @(negedge clk);
    end
    checkOutput("doneAtEnd", doneV[sel], 1);
    checkOutput("readyAtEnd", readyV[sel], 1);
    checkOutput("busyAtEnd", busyV[sel], 0);
    checkOutput("lineAtEnd", lineV[sel], 1);

    if (!keepValid) begin
      @(negedge clk);
      checkOutput("donePulseOnce", doneV[sel], 0);
      checkOutput("lineIdleAfter", lineV[sel], 1);
      checkOutput("readyIdleAfter", readyV[sel], 1);
    end
  endtask

  initial begin
    #600000;
    $display("[TB] FAIL timeout: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset    = 1'b1;
    txValid  = 1'b1;
    txData   = 8'hFF;
    validSel = 2'd0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      checkOutput("resetLine", lineV[s], 1);
      checkOutput("resetReady", readyV[s], 1);
      checkOutput("resetBusy", busyV[s], 0);
      checkOutput("resetDone", doneV[s], 0);
    end
    txValid = 1'b0;
    reset   = 1'b0;

    // Idle line must stay high with no done pulse while nothing is offered.
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      checkOutput("idleLine", lineV[0], 1);
      checkOutput("idleDone", doneV[0], 0);
    end

    applyStimulus(0, 8'hA5, 1'b0, 1'b0);
    applyStimulus(1, 8'h07, 1'b0, 1'b0);
    applyStimulus(2, 8'h07, 1'b0, 1'b0);

    applyStimulus(0, 8'h00, 1'b1, 1'b0);
    applyStimulus(0, 8'hFF, 1'b0, 1'b0);

    applyStimulus(3, 8'h3C, 1'b0, 1'b1);

    // Abort a frame during data bit 3 and make sure it leaves no trace.
    validSel = 2'd0;
    txData   = 8'h3C;
    txValid  = 1'b1;
    @(negedge clk);
    txValid = 1'b0;
    repeat (17) @(negedge clk);
    checkOutput("midFrameBit3", lineV[0], 1);
    checkOutput("midFrameBusy", busyV[0], 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("abortLine", lineV[0], 1);
    checkOutput("abortReady", readyV[0], 1);
    checkOutput("abortBusy", busyV[0], 0);
    checkOutput("abortDone", doneV[0], 0);
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      checkOutput("abortNoDone", doneV[0], 0);
      checkOutput("abortIdleLine", lineV[0], 1);
    end
    applyStimulus(0, 8'h81, 1'b0, 1'b0);

    for (int n = 0; n < 10; n++) begin
      applyStimulus(int'($urandom_range(0, 3)), 8'($urandom), 1'b0, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
